// File: rtl/tybec_axis_pkg.sv
// Shared types and constants for the TyBEC AXI4-Stream output bridge.
package tybec_axis_pkg;

  localparam int TY_GVECT         = 1;
  localparam int C_DATA_WIDTH_DEF = 32 * TY_GVECT;
  localparam int CH_MAX           = 8;
  localparam int DATA_W_MAX       = 512;

  typedef logic [C_DATA_WIDTH_DEF-1:0] chan_word_t;

  // Pointer width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tybec_axis_chan_fifo.sv
// Single-clock register-array FIFO backing one output channel of the fork.
module tybec_axis_chan_fifo
  import tybec_axis_pkg::*;
#(
  parameter int W     = C_DATA_WIDTH_DEF,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_empty
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_cnt;
  logic                    w_push;
  logic                    w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  // Storage is cleared on reset so the output word reads zero while held.
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/tybec_axis_fork.sv
// Fans one main-pipeline output beat out to independent AXI4-Stream master channels.
module tybec_axis_fork
  import tybec_axis_pkg::*;
#(
  parameter int C_DATA_WIDTH   = C_DATA_WIDTH_DEF,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_DEPTH        = 2
) (
  input  logic                                         aclk,
  input  logic                                         areset,
  input  logic                                         i_tvalid,
  input  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  i_tdata,
  output logic                                         i_tready,
  output logic [C_NUM_CHANNELS-1:0]                    m_tvalid,
  output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata,
  input  logic [C_NUM_CHANNELS-1:0]                    m_tready,
  output logic                                         o_idle
);

  logic [C_NUM_CHANNELS-1:0] w_full;
  logic [C_NUM_CHANNELS-1:0] w_empty;
  logic [C_NUM_CHANNELS-1:0] w_pop;
  logic                      w_push;

  // Ready depends only on registered occupancy, so no path from m_tready.
  assign i_tready = ~areset & ~(|w_full);
  assign w_push   = i_tvalid & i_tready;
  assign m_tvalid = ~w_empty;
  assign w_pop    = m_tvalid & m_tready;
  assign o_idle   = &w_empty;

  for (genvar gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_ch
    tybec_axis_chan_fifo #(
      .W     (C_DATA_WIDTH),
      .DEPTH (C_DEPTH)
    ) u_fifo (
      .i_clk   (aclk),
      .i_rst   (areset),
      .i_push  (w_push),
      .i_din   (i_tdata[gi]),
      .o_full  (w_full[gi]),
      .i_pop   (w_pop[gi]),
      .o_dout  (m_tdata[gi]),
      .o_empty (w_empty[gi])
    );
  end

endmodule
